sm510_lcd_scanner: RTL and testbench

- Shares the SM510 4-bit work RAM port between the CPU core and the LCD common/segment scan engine.
- On each scan tick, reads display RAM (32 nibbles at DISP_BASE..DISP_BASE+31) through the arbitrated port.
- Extracts the bit for the current common line and atomically commits segA/segB/H/Bs.
- Replaces direct multi-port RAM reads by the LCD driver.

---
 rtl/sm510_lcd_scanner_if.sv | 25 ++
 rtl/sm510_lcd_scanner.sv | 157 +++++++++++++++
 tb/tb_sm510_lcd_scanner.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm510_lcd_scanner_if.sv
// Shared SM510 work-RAM bus: CPU request/response side plus the single RAM port.
// The slave modport is the scanner/arbiter; the master modport is its environment.
interface sm510_lcd_scanner_if;
  logic       cpu_req;
  logic       cpu_we;
  logic [6:0] cpu_addr;
  logic [3:0] cpu_wdata;
  logic       cpu_gnt;
  logic       cpu_rvalid;
  logic [3:0] cpu_rdata;
  logic [6:0] ram_addr;
  logic       ram_we;
  logic [3:0] ram_wdata;
  logic [3:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/sm510_lcd_scanner.sv
// SM510 LCD scan engine sharing the 4-bit work RAM port with the CPU core.
// Each scan reads all display nibbles into a shadow and commits them atomically.
module sm510_lcd_scanner #(
  parameter logic [6:0] DISP_BASE  = 7'h60,
  parameter int         NUM_SEG    = 32,
  parameter int         STARVE_MAX = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                scan_tick,
  input  logic                disp_en,
  input  logic [3:0]          bs_src,
  sm510_lcd_scanner_if.slave  bus,
  output logic [15:0]         segA,
  output logic [15:0]         segB,
  output logic [3:0]          H,
  output logic                Bs,
  output logic                scan_busy,
  output logic                overrun
);

  localparam int SIW = $clog2(NUM_SEG);
  localparam int SCW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    COMMIT
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [SIW-1:0]     seg_idx;
  logic [SCW-1:0]     starve_cnt;
  logic [1:0]         com_idx;
  logic [NUM_SEG-1:0] shadow;
  logic               cap_valid;
  logic [SIW-1:0]     cap_idx;
  logic               rd_pend;

  logic scan_want;
  logic force_scan;
  logic cpu_gnt_i;
  logic scan_gnt;
  logic last_seg;

  // The CPU normally wins; the scanner steals one cycle once it has been starved long enough.
  assign scan_want  = (state == READ);
  assign force_scan = scan_want && (starve_cnt == SCW'(STARVE_MAX));
  assign cpu_gnt_i  = bus.cpu_req & ~force_scan;
  assign scan_gnt   = scan_want & ~cpu_gnt_i;
  assign last_seg   = (seg_idx == SIW'(NUM_SEG - 1));

  assign bus.cpu_gnt = cpu_gnt_i;
  assign scan_busy   = (state != IDLE);

  always_comb begin
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = '0;
    if (cpu_gnt_i) begin
      bus.ram_addr  = bus.cpu_addr;
      bus.ram_we    = bus.cpu_we;
      bus.ram_wdata = bus.cpu_wdata;
    end else if (scan_want) begin
      bus.ram_addr = DISP_BASE + 7'(seg_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (scan_tick && disp_en) state_next = READ;
      READ:    if (scan_gnt && last_seg) state_next = DRAIN;
      DRAIN:   state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RAM returns data one clock after the address, so both the CPU read and the
  // scanner capture ride a one-stage pipe behind their grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend        <= 1'b0;
      bus.cpu_rvalid <= 1'b0;
      bus.cpu_rdata  <= '0;
      cap_valid      <= 1'b0;
      cap_idx        <= '0;
      shadow         <= '0;
    end else begin
      rd_pend        <= cpu_gnt_i & ~bus.cpu_we;
      bus.cpu_rvalid <= rd_pend;
      if (rd_pend) begin
        bus.cpu_rdata <= bus.ram_rdata;
      end
      cap_valid <= scan_gnt;
      cap_idx   <= seg_idx;
      if (cap_valid) begin
        shadow[cap_idx] <= bus.ram_rdata[com_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_idx    <= '0;
      starve_cnt <= '0;
    end else begin
      if (state == IDLE) begin
        seg_idx <= '0;
      end else if (scan_gnt) begin
        seg_idx <= seg_idx + SIW'(1);
      end

      if (state == IDLE || scan_gnt) begin
        starve_cnt <= '0;
      end else if (scan_want && cpu_gnt_i && starve_cnt != SCW'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + SCW'(1);
      end
    end
  end

  // Visible outputs move only on COMMIT, or are blanked by a disabled tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segA    <= '0;
      segB    <= '0;
      H       <= '0;
      Bs      <= 1'b0;
      com_idx <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= scan_tick && (state != IDLE);
      if (state == IDLE && scan_tick && !disp_en) begin
        H  <= '0;
        Bs <= 1'b0;
      end else if (state == COMMIT) begin
        segA    <= shadow[15:0];
        segB    <= shadow[31:16];
        H       <= 4'b0001 << com_idx;
        Bs      <= bs_src[com_idx];
        com_idx <= com_idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_sm510_lcd_scanner.sv
// Self-checking bench for sm510_lcd_scanner: a behavioural RAM plus a display
// model that predicts each commit from nibble contents and the common index.
module tb_sm510_lcd_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scan_tick = 1'b0;
  logic        disp_en = 1'b0;
  logic [3:0]  bs_src = 4'h0;
  logic [15:0] segA;
  logic [15:0] segB;
  logic [3:0]  H;
  logic        Bs;
  logic        scan_busy;
  logic        overrun;

  sm510_lcd_scanner_if bus ();

  sm510_lcd_scanner dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_tick (scan_tick),
    .disp_en   (disp_en),
    .bs_src    (bs_src),
    .bus       (bus.slave),
    .segA      (segA),
    .segB      (segB),
    .H         (H),
    .Bs        (Bs),
    .scan_busy (scan_busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] d;
  } rd_t;

  logic [3:0] mem [128];
  logic [3:0] ref_mem [128];
  logic       pre_we = 1'b0;
  logic [6:0] pre_addr = '0;
  logic [3:0] pre_data = '0;
  int         checks = 0;
  int         failures = 0;
  int         model_com = 0;

  // Synchronous RAM with one clock of read latency and a preload port for the bench.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  function automatic logic [15:0] exp_bank(input int base, input int com);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = ref_mem[base + i][com];
    return r;
  endfunction

  task automatic poke(input int addr, input logic [3:0] data);
    pre_we = 1'b1;
    pre_addr = 7'(addr);
    pre_data = data;
    ref_mem[addr] = data;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic run_scan(input logic en);
    logic [15:0] pa, pb, ea, eb;
    logic [3:0]  ph, eh;
    logic        ebs;
    pa = segA; pb = segB; ph = H;
    ea = exp_bank('h60, model_com);
    eb = exp_bank('h70, model_com);
    eh = 4'(1 << model_com);
    ebs = bs_src[model_com];
    disp_en = en;
    scan_tick = 1'b1;
    @(posedge clk); #1;
    scan_tick = 1'b0;
    if (!en) begin
      checks++; if (H !== 4'h0) begin failures++; $display("[TB] FAIL dis_H got %b exp 0000", H); end
      checks++; if (Bs !== 1'b0) begin failures++; $display("[TB] FAIL dis_Bs got %b exp 0", Bs); end
      checks++; if (segA !== pa || segB !== pb) begin failures++; $display("[TB] FAIL dis_seg got %h/%h exp %h/%h", segA, segB, pa, pb); end
      checks++; if (scan_busy !== 1'b0) begin failures++; $display("[TB] FAIL dis_busy got %b exp 0", scan_busy); end
      return;
    end
    repeat (33) @(posedge clk);
    #1;
    checks++; if (scan_busy !== 1'b1) begin failures++; $display("[TB] FAIL commit_busy got %b exp 1", scan_busy); end
    checks++; if (segA !== pa || segB !== pb || H !== ph) begin failures++; $display("[TB] FAIL early_update got %h/%h/%b exp %h/%h/%b", segA, segB, H, pa, pb, ph); end
    @(posedge clk); #1;
    checks++; if (segA !== ea) begin failures++; $display("[TB] FAIL scan_segA got %h exp %h", segA, ea); end
    checks++; if (segB !== eb) begin failures++; $display("[TB] FAIL scan_segB got %h exp %h", segB, eb); end
    checks++; if (H !== eh) begin failures++; $display("[TB] FAIL scan_H got %b exp %b", H, eh); end
    checks++; if (Bs !== ebs) begin failures++; $display("[TB] FAIL scan_Bs got %b exp %b", Bs, ebs); end
    checks++; if (scan_busy !== 1'b0) begin failures++; $display("[TB] FAIL scan_done got %b exp 0", scan_busy); end
    model_com = (model_com + 1) % 4;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (segA !== 16'h0 || segB !== 16'h0 || H !== 4'h0 || Bs !== 1'b0 || scan_busy !== 1'b0 ||
        overrun !== 1'b0 || bus.cpu_rvalid !== 1'b0 || bus.cpu_rdata !== 4'h0) begin
      failures++;
      $display("[TB] FAIL %s got segA=%h segB=%h H=%b Bs=%b busy=%b ovr=%b rv=%b rd=%h exp all 0",
               tag, segA, segB, H, Bs, scan_busy, overrun, bus.cpu_rvalid, bus.cpu_rdata);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int a = 0; a < 128; a++) poke(a, 4'($urandom));
    check_all_zero("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_com = 0;
  endtask

  task automatic test_basic_scan();
    for (int a = 'h60; a < 'h80; a++) poke(a, 4'h0);
    poke('h60, 4'b0001);
    poke('h70, 4'b0010);
    bs_src = 4'h0;
    run_scan(1'b1);
    checks++; if (segA !== 16'h0001 || segB !== 16'h0000 || H !== 4'b0001) begin failures++; $display("[TB] FAIL basic_tick1 got %h/%h/%b exp 0001/0000/0001", segA, segB, H); end
    run_scan(1'b1);
    checks++; if (segA !== 16'h0000 || segB !== 16'h0001 || H !== 4'b0010) begin failures++; $display("[TB] FAIL basic_tick2 got %h/%h/%b exp 0000/0001/0010", segA, segB, H); end
    run_scan(1'b1);
    run_scan(1'b1);
    run_scan(1'b1);
    checks++; if (H !== 4'b0001) begin failures++; $display("[TB] FAIL basic_wrap got %b exp 0001", H); end
  endtask

  task automatic test_random_scans();
    for (int n = 0; n < 5; n++) begin
      for (int a = 'h60; a < 'h80; a++) poke(a, 4'($urandom));
      bs_src = 4'($urandom);
      run_scan(1'b1);
    end
  endtask

  task automatic test_disable();
    while (model_com != 3) run_scan(1'b1);
    checks++; if (H !== 4'b0100) begin failures++; $display("[TB] FAIL dis_prior_H got %b exp 0100", H); end
    run_scan(1'b0);
    run_scan(1'b1);
  endtask

  task automatic test_starvation();
    rd_t         q[$];
    logic [15:0] ea, eb;
    logic [3:0]  eh, wd;
    logic [6:0]  a;
    logic        w, exp_g, exp_rv, ebs;
    int          denials;
    denials = 0;
    for (int i = 'h60; i < 'h80; i++) poke(i, 4'($urandom));
    bs_src = 4'($urandom);
    ea = exp_bank('h60, model_com);
    eb = exp_bank('h70, model_com);
    eh = 4'(1 << model_com);
    ebs = bs_src[model_com];
    disp_en = 1'b1;
    scan_tick = 1'b1;
    @(posedge clk); #1;
    scan_tick = 1'b0;
    w = 1'b0; a = '0; wd = '0;
    for (int c = 1; c <= 292; c++) begin
      if (c <= 290) begin
        w = 1'($urandom_range(0, 1));
        a = w ? 7'($urandom_range(0, 'h5F)) : 7'($urandom_range(0, 127));
        wd = 4'($urandom);
        bus.cpu_req = 1'b1; bus.cpu_we = w; bus.cpu_addr = a; bus.cpu_wdata = wd;
      end else begin
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
      end
      @(negedge clk);
      if (c <= 290) begin
        exp_g = !(c <= 288 && c % 9 == 0);
        checks++; if (bus.cpu_gnt !== exp_g) begin failures++; $display("[TB] FAIL starve_gnt c=%0d got %b exp %b", c, bus.cpu_gnt, exp_g); end
        if (bus.cpu_gnt === 1'b0) denials++;
        if (bus.cpu_gnt === 1'b1) begin
          if (w) ref_mem[a] = wd;
          else q.push_back('{cyc: c + 2, d: ref_mem[a]});
        end
      end
      exp_rv = (q.size() > 0) && (q[0].cyc == c);
      checks++; if (bus.cpu_rvalid !== exp_rv) begin failures++; $display("[TB] FAIL cpu_rvalid c=%0d got %b exp %b", c, bus.cpu_rvalid, exp_rv); end
      if (exp_rv) begin
        checks++; if (bus.cpu_rdata !== q[0].d) begin failures++; $display("[TB] FAIL cpu_rdata c=%0d got %h exp %h", c, bus.cpu_rdata, q[0].d); end
        void'(q.pop_front());
      end
      if (c == 291) begin
        checks++;
        if (segA !== ea || segB !== eb || H !== eh || Bs !== ebs || scan_busy !== 1'b0) begin
          failures++;
          $display("[TB] FAIL starve_commit got %h/%h/%b/%b busy=%b exp %h/%h/%b/%b busy=0", segA, segB, H, Bs, scan_busy, ea, eb, eh, ebs);
        end
      end
      @(posedge clk); #1;
    end
    checks++; if (denials != 32) begin failures++; $display("[TB] FAIL starve_denials got %0d exp 32", denials); end
    checks++; if (q.size() != 0) begin failures++; $display("[TB] FAIL starve_pending got %0d exp 0", q.size()); end
    model_com = (model_com + 1) % 4;
  endtask

  task automatic test_overrun();
    logic [15:0] ea, eb;
    logic [3:0]  eh;
    for (int i = 'h60; i < 'h80; i++) poke(i, 4'($urandom));
    ea = exp_bank('h60, model_com);
    eb = exp_bank('h70, model_com);
    eh = 4'(1 << model_com);
    disp_en = 1'b1;
    scan_tick = 1'b1;
    @(posedge clk); #1;
    scan_tick = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL ovr_quiet got %b exp 0", overrun); end
    scan_tick = 1'b1;
    @(posedge clk); #1;
    scan_tick = 1'b0;
    checks++; if (overrun !== 1'b1 || scan_busy !== 1'b1) begin failures++; $display("[TB] FAIL ovr_pulse got ovr=%b busy=%b exp 1/1", overrun, scan_busy); end
    @(posedge clk); #1;
    checks++; if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL ovr_width got %b exp 0", overrun); end
    repeat (22) @(posedge clk);
    #1;
    scan_tick = 1'b1;
    @(posedge clk); #1;
    scan_tick = 1'b0;
    checks++; if (overrun !== 1'b1) begin failures++; $display("[TB] FAIL ovr_commit got %b exp 1", overrun); end
    checks++; if (segA !== ea || segB !== eb || H !== eh) begin failures++; $display("[TB] FAIL ovr_result got %h/%h/%b exp %h/%h/%b", segA, segB, H, ea, eb, eh); end
    model_com = (model_com + 1) % 4;
    @(posedge clk); #1;
    checks++; if (overrun !== 1'b0 || scan_busy !== 1'b0) begin failures++; $display("[TB] FAIL ovr_after got ovr=%b busy=%b exp 0/0", overrun, scan_busy); end
    repeat (40) @(posedge clk);
    #1;
    checks++; if (scan_busy !== 1'b0 || H !== eh) begin failures++; $display("[TB] FAIL ovr_single got busy=%b H=%b exp 0/%b", scan_busy, H, eh); end
  endtask

  task automatic test_bs_coherency();
    logic [1:0]  bs_seen;
    logic [3:0]  bs_exp;
    logic [15:0] ea, eb;
    int          n;
    while (model_com != 0) run_scan(1'b1);
    bs_src = 4'b1010;
    bs_exp = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      run_scan(1'b1);
      bs_seen = {1'b0, Bs};
      checks++; if (bs_seen[0] !== bs_exp[k]) begin failures++; $display("[TB] FAIL bs_seq k=%0d got %b exp %b", k, Bs, bs_exp[k]); end
    end
    poke('h65, 4'h0);
    disp_en = 1'b1;
    scan_tick = 1'b1;
    @(posedge clk); #1;
    scan_tick = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 7'h65; bus.cpu_wdata = 4'hF;
    @(negedge clk);
    checks++; if (bus.cpu_gnt !== 1'b1) begin failures++; $display("[TB] FAIL coh_gnt got %b exp 1", bus.cpu_gnt); end
    ref_mem['h65] = 4'hF;
    ea = exp_bank('h60, model_com);
    eb = exp_bank('h70, model_com);
    @(posedge clk); #1;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    n = 1;
    while (scan_busy === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n != 35) begin failures++; $display("[TB] FAIL coh_latency got %0d exp 35", n); end
    checks++; if (segA !== ea || segB !== eb) begin failures++; $display("[TB] FAIL coh_seg got %h/%h exp %h/%h", segA, segB, ea, eb); end
    checks++; if (segA[5] !== 1'b1) begin failures++; $display("[TB] FAIL coh_bit5 got %b exp 1", segA[5]); end
    model_com = (model_com + 1) % 4;
  endtask

  task automatic test_reset_midscan();
    for (int i = 'h60; i < 'h80; i++) poke(i, 4'hF);
    run_scan(1'b1);
    disp_en = 1'b1;
    scan_tick = 1'b1;
    @(posedge clk); #1;
    scan_tick = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_midscan");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_com = 0;
    run_scan(1'b1);
    checks++; if (H !== 4'b0001) begin failures++; $display("[TB] FAIL reset_restart got %b exp 0001", H); end
  endtask

  initial begin
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    test_reset();
    test_basic_scan();
    test_random_scans();
    test_disable();
    test_starvation();
    test_overrun();
    test_bs_coherency();
    test_reset_midscan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout exp completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
